toggle_stream_decoder: RTL and testbench

//   Receive end of the toggle-encoded serial line.
//   - The transmit side is a T latch/flop: its q output toggles when t=1 and holds when t=0.
//   - This block samples that line level once per bit strobe.
//   - It recovers each t bit as the XOR of the current and previous line level.
//   - It frames the recovered bits as: start bit, WIDTH data bits, stop bit.
//   - It presents each completed word with a one-cycle valid pulse.
//   - It sits directly after the T-latch stage, in the same clock domain.
//   - line_in is synchronous to clk; no synchroniser is included.
//

---
 rtl/toggle_stream_decoder.sv | 128 ++++++++++++
 tb/tb_toggle_stream_decoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/toggle_stream_decoder.sv
// ---------------------------------------------------------------------------
// toggle_stream_decoder
//
// Receive end of a toggle-encoded serial line. The transmitter is a T flop
// whose q toggles for every t=1 bit. This block samples the line once per bit
// strobe and recovers each t bit as line_in ^ prev_line. It then frames the
// recovered bits as start(1), WIDTH data bits (LSB first) and stop(0).
//
// Handshake: bit_valid, data_valid and frame_err are single-cycle pulses with
// no back-pressure. A consumer must take data_out in the cycle where
// data_valid=1; the value stays there until the next good frame.
//
// Ports
//   clk        in   clock, all state updates on posedge
//   rst        in   asynchronous active-high reset
//   bit_en     in   bit strobe; line_in is sampled only when bit_en=1
//   line_in    in   toggle-encoded line level (transmitter's q)
//   bit_out    out  last recovered bit
//   bit_valid  out  pulse: bit_out updated this cycle
//   data_out   out  last correctly framed word
//   data_valid out  pulse: data_out updated this cycle
//   frame_err  out  pulse: stop bit was 1
//   busy       out  1 while the framer is not IDLE (state visible to checkers)
// ---------------------------------------------------------------------------
module toggle_stream_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             line_in,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] data_nx;
    logic             dv_nx, fe_nx;
    logic             prev_line;
    logic             b;

    // Recovered t bit: the line toggled iff the transmitter saw t=1.
    assign b    = line_in ^ prev_line;
    assign busy = (state != IDLE);

    // Next-state and framed-output logic; only advances on strobe cycles.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        data_nx  = data_out;
        dv_nx    = 1'b0;
        fe_nx    = 1'b0;
        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (b) begin
                        state_nx = DATA;
                        cnt_nx   = '0;
                    end
                end
                DATA: begin
                    shreg_nx[cnt] = b;
                    if (cnt == CNT_LAST) begin
                        state_nx = STOP;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                STOP: begin
                    // A toggling stop bit is consumed here, not reused as a start.
                    state_nx = IDLE;
                    if (b) begin
                        fe_nx = 1'b1;
                    end else begin
                        data_nx = shreg;
                        dv_nx   = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            prev_line  <= 1'b0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            shreg      <= shreg_nx;
            data_out   <= data_nx;
            data_valid <= dv_nx;
            frame_err  <= fe_nx;
            bit_valid  <= bit_en;
            if (bit_en) begin
                prev_line <= line_in;
                bit_out   <= b;
            end
        end
    end

endmodule

// File: tb/tb_toggle_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_toggle_stream_decoder
//
// Bench for toggle_stream_decoder. The reference is a transmitter model (a
// T flop driving the line) plus frame-level expectations: each sent frame is
// known as (word, stop_error), so the expected data_out/data_valid/frame_err
// follow directly from what was sent.
// ---------------------------------------------------------------------------
module tb_toggle_stream_decoder;

    localparam int W = 8;

    // clock / reset
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         bit_en = 1'b0;
    logic         line_in = 1'b0;
    logic         bit_out, bit_valid, data_valid, frame_err, busy;
    logic [W-1:0] data_out;

    always #5 clk = ~clk;

    toggle_stream_decoder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .line_in    (line_in),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // scoreboard state
    int           n_checks = 0;
    int           n_errors = 0;
    logic         tx_q = 1'b0;         // transmitter T flop output
    logic [W-1:0] last_good = '0;      // last word framed correctly
    logic [W-1:0] exp_q[$];            // words expected on data_valid
    int           bv_count = 0;        // bit_valid pulses seen
    int           dv_cycle_q[$];       // cycles where data_valid was seen

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // driver: idle cycles with no strobe; outputs must not pulse
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bit_en = 1'b0;
            @(posedge clk);
            #1;
            check("gap_bit_valid", bit_valid, 0);
            check("gap_data_valid", data_valid, 0);
            check("gap_frame_err", frame_err, 0);
        end
    endtask

    // driver: one strobed t bit through the transmitter model
    task automatic send_bit(input logic t, input bit is_stop, input bit exp_busy, input int gap);
        logic exp_dv, exp_fe;
        tx_q    = tx_q ^ t;
        line_in = tx_q;
        bit_en  = 1'b1;
        @(posedge clk);
        #1;
        bit_en = 1'b0;
        exp_dv = is_stop && !t;
        exp_fe = is_stop && t;
        if (exp_dv) last_good = exp_q.pop_front();
        check("bit_valid", bit_valid, 1);
        check("bit_out", bit_out, t);
        check("data_valid", data_valid, exp_dv);
        check("frame_err", frame_err, exp_fe);
        check("data_out", data_out, last_good);
        check("busy", busy, exp_busy);
        if (bit_valid) bv_count++;
        if (data_valid) dv_cycle_q.push_back(cycle);
        idle_cycles(gap);
    endtask

    task automatic send_frame(input logic [W-1:0] word, input bit bad_stop, input int gap);
        if (!bad_stop) exp_q.push_back(word);
        send_bit(1'b1, 0, 1, gap);
        for (int i = 0; i < W; i++) send_bit(word[i], 0, (i != W - 1) || 1'b1, gap);
        send_bit(bad_stop, 1, 0, gap);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bit_out"}, bit_out, 0);
        check({tag, "_bit_valid"}, bit_valid, 0);
        check({tag, "_data_out"}, data_out, 0);
        check({tag, "_data_valid"}, data_valid, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // asynchronous reset pulse between edges; the model resets with it
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero(tag);
        #7;
        rst = 1'b0;
        tx_q = 1'b0;
        line_in = 1'b0;
        last_good = '0;
        exp_q.delete();
    endtask

    initial begin
        logic [W-1:0] w;
        bit           bad;
        int           nb;

        // power-on reset
        rst = 1'b1;
        #12;
        check_all_zero("por");
        rst = 1'b0;
        idle_cycles(2);

        // 1: reset in DATA with cnt=3 (start + 3 data bits taken)
        send_bit(1'b1, 0, 1, 0);
        send_bit(1'b1, 0, 1, 0);
        send_bit(1'b0, 0, 1, 0);
        send_bit(1'b1, 0, 1, 0);
        async_reset("rst_cnt3");
        idle_cycles(1);

        // 2: good frame 0xA5
        send_frame(8'hA5, 0, 0);
        idle_cycles(2);
        check("a5_word", data_out, 8'hA5);

        // 3: bad stop, data_out keeps 0xA5
        send_frame(8'h5A, 1, 0);
        idle_cycles(1);
        check("badstop_hold", data_out, 8'hA5);
        // the absorbed toggle is not a start: zero bits keep the framer idle
        send_bit(1'b0, 0, 0, 0);

        // 4: strobe gaps of 3 cycles, 10 bit_valid pulses
        bv_count = 0;
        send_frame(8'h3C, 0, 3);
        check("gap_bv_count", bv_count, 10);
        check("gap_word", data_out, 8'h3C);

        // 5: back-to-back 0x00 then 0xFF, strobe every cycle
        dv_cycle_q.delete();
        send_frame(8'h00, 0, 0);
        send_frame(8'hFF, 0, 0);
        check("b2b_pulses", dv_cycle_q.size(), 2);
        if (dv_cycle_q.size() == 2)
            check("b2b_spacing", dv_cycle_q[1] - dv_cycle_q[0], 10);
        check("b2b_word", data_out, 8'hFF);

        // 6: reset during data bit 4, then frame 0x81
        send_bit(1'b1, 0, 1, 0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 0, 1, 0);
        async_reset("rst_bit4");
        send_frame(8'h81, 0, 0);
        idle_cycles(1);
        check("recover_word", data_out, 8'h81);

        // randomized frames: random word, stop error, idle bits, strobe gaps
        for (int f = 0; f < 40; f++) begin
            w   = W'($urandom_range(0, (1 << W) - 1));
            bad = ($urandom_range(0, 4) == 0);
            nb  = $urandom_range(0, 2);
            for (int k = 0; k < nb; k++) send_bit(1'b0, 0, 0, $urandom_range(0, 1));
            send_frame(w, bad, $urandom_range(0, 2));
        end
        check("exp_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
